pipeline_hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage pipeline.
//  - Drives the stall/flush inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC hold.
//  - Resolves load-use hazards, EX-stage redirects (branch/jump), and imem/dmem wait states.
//  - Discards fetches that are in flight across a redirect.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/hazard_perf_cnt.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline control types: controller FSM states, the per-register stall/flush bundle,
// and the x0 register index that never creates a data dependency.
package riscv_pkg;

   typedef enum logic {
      RUN       = 1'b0,
      DMEM_WAIT = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_stall;
      logic id_ex_flush;
      logic ex_mem_stall;
      logic ex_mem_flush;
      logic mem_wb_stall;
      logic mem_wb_flush;
   } hazard_ctrl_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   function automatic logic src_hits(input logic uses, input logic [4:0] src, input logic [4:0] rd);
      return uses && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running wrap-around event counters for hazard activity; 1-cycle update latency.
// Counts whatever the controller reports each cycle; never backpressures.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             lu_evt,
   input  logic             dwait_evt,
   input  logic             redir_evt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] dwait_cnt,
   output logic [CNT_W-1:0] redir_cnt
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lu_cnt    <= '0;
         dwait_cnt <= '0;
         redir_cnt <= '0;
      end else begin
         if (lu_evt)    lu_cnt    <= lu_cnt + CNT_W'(1);
         if (dwait_evt) dwait_cnt <= dwait_cnt + CNT_W'(1);
         if (redir_evt) redir_cnt <= redir_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline (perf counters under STALL_CNT_EN).
// Latency: stall/flush are combinational, same cycle; only FSM, kill and timeout are registered.
// Backpressure: dmem wait freezes everything up to EX/MEM; imem miss holds the PC only.
module pipeline_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 256,
   parameter int CNT_W        = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_mem_read,
   input  logic       ex_redirect,
   input  logic       imem_ready,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       if_id_flush,
   output logic       id_ex_stall,
   output logic       id_ex_flush,
   output logic       ex_mem_stall,
   output logic       ex_mem_flush,
   output logic       mem_wb_stall,
   output logic       mem_wb_flush,
   output logic       mem_timeout
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_lu_cnt,
   output logic [CNT_W-1:0] perf_dwait_cnt,
   output logic [CNT_W-1:0] perf_redir_cnt
`endif
);

   localparam int                WCNT_W    = $clog2(WAIT_TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);

   if (WAIT_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
      $error("pipeline_hazard_ctrl: WAIT_TIMEOUT must be >= 2 and CNT_W >= 1");
   end

   ctrl_state_t       state, state_nxt;
   logic              kill_pending, kill_nxt;
   logic [WCNT_W-1:0] wait_cnt;
   hazard_ctrl_t      ctl;
   logic              dwait, load_use;

   assign dwait    = dmem_req && !dmem_ready;
   assign load_use = ex_mem_read && (ex_rd_addr != REG_X0) &&
                     (src_hits(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                      src_hits(id_uses_rs2, id_rs2_addr, ex_rd_addr));

   always_comb begin
      ctl = '0;
      if (!reset_n) begin
         ctl.if_id_flush  = 1'b1;
         ctl.id_ex_flush  = 1'b1;
         ctl.ex_mem_flush = 1'b1;
         ctl.mem_wb_flush = 1'b1;
      end else if (dwait) begin
         ctl.pc_stall     = 1'b1;
         ctl.if_id_stall  = 1'b1;
         ctl.id_ex_stall  = 1'b1;
         ctl.ex_mem_stall = 1'b1;
         ctl.mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         ctl.if_id_flush  = 1'b1;
         ctl.id_ex_flush  = 1'b1;
      end else begin
         if (load_use) begin
            ctl.pc_stall    = 1'b1;
            ctl.if_id_stall = 1'b1;
            ctl.id_ex_flush = 1'b1;
         end
         if (!imem_ready) ctl.pc_stall = 1'b1;
         // A stale fetch landing after a redirect is dropped like a miss; a load-use hold wins.
         if (!load_use && (!imem_ready || kill_pending)) ctl.if_id_flush = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:       if (dwait)      state_nxt = DMEM_WAIT;
         DMEM_WAIT: if (dmem_ready) state_nxt = RUN;
         default:                   state_nxt = RUN;
      endcase
   end

   always_comb begin
      kill_nxt = kill_pending;
      if (!dwait) begin
         if (ex_redirect)     kill_nxt = kill_pending || !imem_ready;
         else if (imem_ready) kill_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= RUN;
         kill_pending <= 1'b0;
         wait_cnt     <= '0;
         mem_timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         kill_pending <= kill_nxt;
         if (state == DMEM_WAIT) begin
            if (dmem_ready) begin
               wait_cnt <= '0;
            end else begin
               if (wait_cnt != WCNT_LAST) wait_cnt <= wait_cnt + WCNT_W'(1);
               if (wait_cnt == WCNT_LAST) mem_timeout <= 1'b1;
            end
         end
      end
   end

   assign pc_stall     = ctl.pc_stall;
   assign if_id_stall  = ctl.if_id_stall;
   assign if_id_flush  = ctl.if_id_flush;
   assign id_ex_stall  = ctl.id_ex_stall;
   assign id_ex_flush  = ctl.id_ex_flush;
   assign ex_mem_stall = ctl.ex_mem_stall;
   assign ex_mem_flush = ctl.ex_mem_flush;
   assign mem_wb_stall = ctl.mem_wb_stall;
   assign mem_wb_flush = ctl.mem_wb_flush;

`ifdef STALL_CNT_EN
   hazard_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk       (clk),
      .reset_n   (reset_n),
      .lu_evt    (load_use && !dwait && !ex_redirect),
      .dwait_evt (dwait),
      .redir_evt (ex_redirect && !dwait),
      .lu_cnt    (perf_lu_cnt),
      .dwait_cnt (perf_dwait_cnt),
      .redir_cnt (perf_redir_cnt)
   );
`endif

endmodule
